// File: rtl/hicore_icb_arb2.sv
// rtl/hicore_icb_arb2.sv - two-master ICB arbiter onto one slave port with in-order response routing
`ifndef HiCore_ADDR_SIZE
`define HiCore_ADDR_SIZE 32
`endif
`ifndef HiCore_REG_SIZE
`define HiCore_REG_SIZE 32
`endif

module hicore_icb_arb2 #(
  parameter int OUTS_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m0_icb_cmd_valid,
  output logic                           m0_icb_cmd_ready,
  input  logic                           m0_icb_cmd_read,
  input  logic [`HiCore_ADDR_SIZE-1:0]   m0_icb_cmd_addr,
  input  logic [`HiCore_REG_SIZE-1:0]    m0_icb_cmd_wdata,
  input  logic [`HiCore_REG_SIZE/8-1:0]  m0_icb_cmd_wmask,
  output logic                           m0_icb_rsp_valid,
  input  logic                           m0_icb_rsp_ready,
  output logic [`HiCore_REG_SIZE-1:0]    m0_icb_rsp_rdata,
  output logic                           m0_icb_rsp_err,
  input  logic                           m1_icb_cmd_valid,
  output logic                           m1_icb_cmd_ready,
  input  logic                           m1_icb_cmd_read,
  input  logic [`HiCore_ADDR_SIZE-1:0]   m1_icb_cmd_addr,
  input  logic [`HiCore_REG_SIZE-1:0]    m1_icb_cmd_wdata,
  input  logic [`HiCore_REG_SIZE/8-1:0]  m1_icb_cmd_wmask,
  output logic                           m1_icb_rsp_valid,
  input  logic                           m1_icb_rsp_ready,
  output logic [`HiCore_REG_SIZE-1:0]    m1_icb_rsp_rdata,
  output logic                           m1_icb_rsp_err,
  output logic                           s_icb_cmd_valid,
  input  logic                           s_icb_cmd_ready,
  output logic                           s_icb_cmd_read,
  output logic [`HiCore_ADDR_SIZE-1:0]   s_icb_cmd_addr,
  output logic [`HiCore_REG_SIZE-1:0]    s_icb_cmd_wdata,
  output logic [`HiCore_REG_SIZE/8-1:0]  s_icb_cmd_wmask,
  input  logic                           s_icb_rsp_valid,
  output logic                           s_icb_rsp_ready,
  input  logic [`HiCore_REG_SIZE-1:0]    s_icb_rsp_rdata,
  input  logic                           s_icb_rsp_err
);

  // Owner storage is a fixed 4-entry vector (the largest legal depth);
  // pointers wrap at OUTS_DEPTH-1 so only the first OUTS_DEPTH entries are used.
  localparam logic [1:0] PTR_LAST = 2'(OUTS_DEPTH - 1);
  localparam logic [2:0] CNT_FULL = 3'(OUTS_DEPTH);

  logic [3:0] r_owner;
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_cnt;
  logic       r_lock;
  logic       r_lock_id;
  logic       r_rr_last;

  logic       w_full;
  logic       w_empty;
  logic       w_head;
  logic       w_gnt;
  logic       w_gnt_valid;
  logic       w_push;
  logic       w_pop;

  assign w_full  = (r_cnt == CNT_FULL);
  assign w_empty = (r_cnt == 3'd0);
  assign w_head  = r_owner[r_rptr];

  // Grant: a stalled command keeps its grant, otherwise round-robin on contention
  always_comb begin
    w_gnt = 1'b0;
    if (r_lock) begin
      w_gnt = r_lock_id;
    end else if (m0_icb_cmd_valid && m1_icb_cmd_valid) begin
      w_gnt = ~r_rr_last;
    end else if (m1_icb_cmd_valid) begin
      w_gnt = 1'b1;
    end
  end

  assign w_gnt_valid     = w_gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
  assign s_icb_cmd_valid = w_gnt_valid && !w_full;
  assign s_icb_cmd_read  = w_gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_addr  = w_gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_wdata = w_gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = w_gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

  // Ready is also qualified by the master's own valid so an idle master never sees ready
  assign m0_icb_cmd_ready = !w_gnt && m0_icb_cmd_valid && s_icb_cmd_ready && !w_full;
  assign m1_icb_cmd_ready =  w_gnt && m1_icb_cmd_valid && s_icb_cmd_ready && !w_full;

  assign w_push = s_icb_cmd_valid && s_icb_cmd_ready;

  // Responses go only to the master that owns the oldest outstanding command
  assign m0_icb_rsp_valid = s_icb_rsp_valid && !w_empty && !w_head;
  assign m1_icb_rsp_valid = s_icb_rsp_valid && !w_empty &&  w_head;
  assign s_icb_rsp_ready  = !w_empty && (w_head ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m0_icb_rsp_err   = s_icb_rsp_err;
  assign m1_icb_rsp_err   = s_icb_rsp_err;

  assign w_pop = s_icb_rsp_valid && s_icb_rsp_ready;

  // Owner FIFO: record issuer on command handshake, retire on response handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 4'd0;
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_cnt   <= 3'd0;
    end else begin
      if (w_push) begin
        r_owner[r_wptr] <= w_gnt;
        r_wptr          <= (r_wptr == PTR_LAST) ? 2'd0 : r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_LAST) ? 2'd0 : r_rptr + 2'd1;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + 3'd1;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  // Grant lock while the slave stalls, and round-robin history of the last handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_lock    <= s_icb_cmd_valid && !s_icb_cmd_ready;
      r_lock_id <= w_gnt;
      if (w_push) begin
        r_rr_last <= w_gnt;
      end
    end
  end

endmodule

// File: doc/hicore_icb_arb2.md
HICORE_ICB_ARB2 -- requirements
Module: hicore_icb_arb2

Interface
REQ-001 The block SHALL share one ICB slave port (e.g. the PLIC register port) between two ICB masters, m0 and m1, with in-order responses.
REQ-002 The block SHALL have one parameter: OUTS_DEPTH, default 2, maximum outstanding commands (1..4).
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock for all state
- rst_n  in  1  reset, asynchronous, active-low
- mN_icb_cmd_valid  in  1  master N command valid (N=0,1)
- mN_icb_cmd_ready  out  1  master N command accepted
- mN_icb_cmd_read  in  1  1=read, 0=write
- mN_icb_cmd_addr  in  `HiCore_ADDR_SIZE  address
- mN_icb_cmd_wdata  in  `HiCore_REG_SIZE  write data
- mN_icb_cmd_wmask  in  `HiCore_REG_SIZE/8  byte mask
- mN_icb_rsp_valid  out  1  response valid to master N
- mN_icb_rsp_ready  in  1  master N accepts response
- mN_icb_rsp_rdata  out  `HiCore_REG_SIZE  read data
- mN_icb_rsp_err  out  1  error flag
- s_icb_cmd_valid/ready/read/addr/wdata/wmask  out/in/out/out/out/out  same widths  slave command
- s_icb_rsp_valid/ready/rdata/err  in/out/in/in  same widths  slave response

Function
REQ-004 A command handshake SHALL occur on s_icb_cmd_valid && s_icb_cmd_ready; a response handshake on s_icb_rsp_valid && s_icb_rsp_ready.
REQ-005 An owner FIFO (depth OUTS_DEPTH, 1-bit entries) SHALL record the master ID of each accepted command, written on command handshake, read on response handshake.
REQ-006 When the FIFO is full, s_icb_cmd_valid and both mN_icb_cmd_ready SHALL be 0, even if a pop occurs in the same cycle.
REQ-007 Arbitration SHALL be round-robin: when both masters are valid and no grant is locked, the master not granted last SHALL win; a single valid master SHALL win immediately.
REQ-008 Register rr_last SHALL record the master of the most recent command handshake; reset value 1, so m0 wins the first contention.
REQ-009 Grant lock: if s_icb_cmd_valid=1 and s_icb_cmd_ready=0, the grant SHALL be held unchanged next cycle regardless of the other master's request.
REQ-010 Command path SHALL be combinational (zero added latency): s_icb_cmd_* = granted master's fields; s_icb_cmd_valid = granted mN_icb_cmd_valid && !full; mN_icb_cmd_ready = granted && s_icb_cmd_ready && !full; non-granted master ready = 0.
REQ-011 Response path SHALL be combinational: rsp fields fan out to both masters; only the master at FIFO head SHALL see mN_icb_rsp_valid = s_icb_rsp_valid; s_icb_rsp_ready = head master's mN_icb_rsp_ready.
REQ-012 With FIFO empty, s_icb_rsp_ready SHALL be 0 and both mN_icb_rsp_valid SHALL be 0 (stray response ignored).
REQ-013 Simultaneous push and pop with FIFO not full SHALL keep count unchanged and advance both pointers; pointers wrap modulo OUTS_DEPTH.
REQ-014 FIFO count SHALL never exceed OUTS_DEPTH nor underflow below 0.
REQ-015 The block SHALL not alter read, addr, wdata, wmask, rdata or err values.

Reset
REQ-016 On rst_n low, asynchronously: FIFO empty (pointers, count = 0), grant lock cleared, rr_last = 1.
REQ-017 During and after reset until a valid request: all mN_icb_cmd_ready = 0, all mN_icb_rsp_valid = 0, s_icb_cmd_valid = 0, s_icb_rsp_ready = 0.
REQ-018 Reset asserted mid-transaction SHALL discard all outstanding ownership; responses arriving afterwards SHALL be ignored per REQ-012.

Verification
REQ-019 Contention: m0 and m1 valid every cycle, slave always ready, rsp returned 1 cycle later -> grants alternate m0,m1,m0,m1; each response reaches the issuing master only.
REQ-020 Lock: m1 valid alone, s_icb_cmd_ready=0 for 3 cycles, m0 raises valid in cycle 2 -> s_icb_cmd_addr stays m1's address until handshake; m0 granted next.
REQ-021 Full: OUTS_DEPTH=2, slave ready, responses withheld, two commands accepted -> third command sees cmd_ready=0 until a response handshake, including in the pop cycle.
REQ-022 Backpressure: response for m0 at head with m0_icb_rsp_ready=0 for 4 cycles -> s_icb_rsp_ready=0 those cycles, m1 rsp_valid=0, rdata 0xDEADBEEF delivered intact to m0.
REQ-023 Reset mid-flight: one command outstanding, rst_n pulsed low -> FIFO empty; subsequent s_icb_rsp_valid=1 yields s_icb_rsp_ready=0 and no master rsp_valid.
REQ-024 Stray response: after reset, s_icb_rsp_valid=1 with no command issued -> both mN_icb_rsp_valid=0, FIFO count stays 0.
